// File: rtl/perpendicularize_pkg.sv
// Shared widths, fixed-point constants and FSM state encoding for the perpendicularize block.
package perpendicularize_pkg;

  localparam int unsigned M_W        = 25;
  localparam int unsigned B_W        = 18;
  localparam int unsigned X_W        = 11;
  localparam int unsigned Y_W        = 10;
  localparam int unsigned FRAC_BITS  = 8;
  localparam int unsigned DIV_CYCLES = 24;

  localparam int unsigned ONE_SQ = 65536;
  localparam logic [M_W-1:0] M_SAT = 25'h0FF_FFFF;
  localparam int B_MAX = 131071;
  localparam int B_MIN = -131072;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVIDE  = 2'd1,
    COMBINE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/perpendicularize_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done_c flags the final iteration cycle.
module perpendicularize_divider #(
  parameter int unsigned N_W        = 24,
  parameter int unsigned D_W        = 25,
  parameter int unsigned DIV_CYCLES = 24
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           start_in,
  input  logic [N_W-1:0] dividend_in,
  input  logic [D_W-1:0] divisor_in,
  output logic [N_W-1:0] quotient,
  output logic           done_c
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0]   quo_q, quo_d;
  logic [D_W-1:0]   rem_q, rem_d;
  logic [D_W-1:0]   div_q, div_d;
  logic [D_W:0]     trial_c;
  logic [D_W:0]     sub_c;
  logic             ge_c;

  // The dividend shifts out of quo_q's MSB while quotient bits shift in at the LSB.
  always_comb begin
    trial_c = {rem_q, quo_q[N_W-1]};
    sub_c   = trial_c - {1'b0, div_q};
    ge_c    = (trial_c >= {1'b0, div_q});
    done_c  = busy_q && (cnt_q == CNT_W'(DIV_CYCLES - 1));

    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    div_d  = div_q;

    if (start_in) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend_in;
      rem_d  = '0;
      div_d  = divisor_in;
    end else if (busy_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      quo_d = {quo_q[N_W-2:0], ge_c};
      rem_d = ge_c ? sub_c[D_W-1:0] : trial_c[D_W-1:0];
      if (done_c) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/perpendicularize.sv
// Perpendicular line through the centre of mass: m_out = -1/m, b_out = y_com - m_out*x_com.
// Define PERP_ROUND_EN for round-to-nearest division and product shift; default truncates/floors.
module perpendicularize
  import perpendicularize_pkg::*;
#(
  parameter int unsigned FRAC_BITS  = perpendicularize_pkg::FRAC_BITS,
  parameter int unsigned DIV_CYCLES = perpendicularize_pkg::DIV_CYCLES
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic signed [M_W-1:0] m_in,
  input  logic signed [B_W-1:0] b_in,
  input  logic        [X_W-1:0] x_com,
  input  logic        [Y_W-1:0] y_com,
  input  logic                  valid_in,
  input  logic                  tabulate_in,
  output logic signed [M_W-1:0] m_out,
  output logic signed [B_W-1:0] b_out,
  output logic                  valid_out
);

  localparam int unsigned N_W    = DIV_CYCLES;
  localparam int unsigned P_W    = M_W + X_W + 1;
  localparam int unsigned B_WIDE = P_W + 1;

  state_e state_q, state_d;

  logic                  m_neg_q, m_neg_d;
  logic                  m_zero_q, m_zero_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [M_W-1:0] m_res_q, m_res_d;
  logic signed [B_W-1:0] b_res_q, b_res_d;
  logic signed [M_W-1:0] m_out_q, m_out_d;
  logic signed [B_W-1:0] b_out_q, b_out_d;
  logic                  valid_out_q, valid_out_d;

  logic                  start_c;
  logic [M_W-1:0]        m_abs_c;
  logic [N_W-1:0]        dividend_c;
  logic [N_W-1:0]        quotient;
  logic                  div_done_c;
  logic signed [M_W-1:0] m_perp_c;
  logic signed [P_W-1:0] x_s_c;
  logic signed [P_W-1:0] prod_c;
  logic signed [P_W-1:0] shifted_c;
  logic signed [B_WIDE-1:0] b_wide_c;
  logic signed [B_W-1:0] b_sat_c;
  logic                  unused_b_c;

  // The input intercept plays no part in the perpendicular line.
  assign unused_b_c = ^b_in;

  assign start_c = (state_q == IDLE) && valid_in && !tabulate_in;
  assign m_abs_c = m_in[M_W-1] ? (M_W'(0) - M_W'(m_in)) : M_W'(m_in);

`ifdef PERP_ROUND_EN
  assign dividend_c = N_W'(ONE_SQ) + N_W'(m_abs_c >> 1);
`else
  assign dividend_c = N_W'(ONE_SQ);
`endif

  perpendicularize_divider #(
    .N_W        (N_W),
    .D_W        (M_W),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_divider (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_c),
    .dividend_in (dividend_c),
    .divisor_in  (m_abs_c),
    .quotient    (quotient),
    .done_c      (div_done_c)
  );

  // Intercept arithmetic on the finished quotient; held stable by the divider once done.
  always_comb begin
    m_perp_c = m_neg_q ? $signed(M_W'(quotient)) : $signed(M_W'(0) - M_W'(quotient));
    x_s_c    = $signed(P_W'(x_q));
    prod_c   = P_W'(m_perp_c) * x_s_c;
`ifdef PERP_ROUND_EN
    prod_c   = prod_c + $signed(P_W'(1) << (FRAC_BITS - 1));
`endif
    shifted_c = prod_c >>> FRAC_BITS;
    b_wide_c  = $signed(B_WIDE'(y_q)) - B_WIDE'(shifted_c);
    if (b_wide_c > B_MAX) begin
      b_sat_c = B_W'(B_MAX);
    end else if (b_wide_c < B_MIN) begin
      b_sat_c = B_W'(B_MIN);
    end else begin
      b_sat_c = b_wide_c[B_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    m_neg_d     = m_neg_q;
    m_zero_d    = m_zero_q;
    x_d         = x_q;
    y_d         = y_q;
    m_res_d     = m_res_q;
    b_res_d     = b_res_q;
    m_out_d     = m_out_q;
    b_out_d     = b_out_q;
    valid_out_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          m_neg_d  = m_in[M_W-1];
          m_zero_d = (m_in == '0);
          x_d      = x_com;
          y_d      = y_com;
          state_d  = DIVIDE;
        end
      end
      DIVIDE: begin
        if (div_done_c) begin
          state_d = COMBINE;
        end
      end
      COMBINE: begin
        // A horizontal input has no finite reciprocal: saturate slope, line passes through y_com.
        m_res_d = m_zero_q ? $signed(M_SAT) : m_perp_c;
        b_res_d = m_zero_q ? $signed(B_W'(y_q)) : b_sat_c;
        state_d = DONE;
      end
      DONE: begin
        m_out_d     = m_res_q;
        b_out_d     = b_res_q;
        valid_out_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      m_neg_q     <= 1'b0;
      m_zero_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      m_res_q     <= '0;
      b_res_q     <= '0;
      m_out_q     <= '0;
      b_out_q     <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_neg_q     <= m_neg_d;
      m_zero_q    <= m_zero_d;
      x_q         <= x_d;
      y_q         <= y_d;
      m_res_q     <= m_res_d;
      b_res_q     <= b_res_d;
      m_out_q     <= m_out_d;
      b_out_q     <= b_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign m_out     = m_out_q;
  assign b_out     = b_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_perpendicularize.sv
// Directed self-checking bench for perpendicularize (default build; PERP_ROUND_EN adjusts one vector).
module tb_perpendicularize;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [24:0] m_in;
  logic signed [17:0] b_in;
  logic [10:0]        x_com;
  logic [9:0]         y_com;
  logic               valid_in;
  logic               tabulate_in;
  logic signed [24:0] m_out;
  logic signed [17:0] b_out;
  logic               valid_out;

  int checks = 0;
  int errors = 0;

  perpendicularize dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .m_in        (m_in),
    .b_in        (b_in),
    .x_com       (x_com),
    .y_com       (y_com),
    .valid_in    (valid_in),
    .tabulate_in (tabulate_in),
    .m_out       (m_out),
    .b_out       (b_out),
    .valid_out   (valid_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one request; returns at the negedge after the accepting edge.
  task automatic do_req(input int m, input int x, input int y, input int b);
    @(negedge clk_in);
    m_in     = 25'(m);
    x_com    = 11'(x);
    y_com    = 10'(y);
    b_in     = 18'(b);
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int em, input int eb);
    int k;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in);
      if (valid_out === 1'b1) begin
        k = i;
        break;
      end
    end
    check({tag, "_latency"}, k, 26);
    check({tag, "_m"}, m_out, em);
    check({tag, "_b"}, b_out, eb);
    @(negedge clk_in);
    check({tag, "_pulse_end"}, valid_out, 0);
  endtask

  task automatic count_pulses(input int cycles, output int n, output int lm, output int lb);
    n  = 0;
    lm = 0;
    lb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_in);
      if (valid_out === 1'b1) begin
        n++;
        lm = int'(m_out);
        lb = int'(b_out);
      end
    end
  endtask

  initial begin
    int n, lm, lb;
    rst_in      = 1'b1;
    m_in        = '0;
    b_in        = '0;
    x_com       = '0;
    y_com       = '0;
    valid_in    = 1'b0;
    tabulate_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    check("reset_m", m_out, 0);
    check("reset_b", b_out, 0);
    check("reset_valid", valid_out, 0);

    do_req(1, 100, 500, 300);
    expect_result("m1", -65536, 26100);
    repeat (3) @(negedge clk_in);
    check("hold_m", m_out, -65536);
    check("hold_b", b_out, 26100);

    do_req(256, 100, 500, 0);
    expect_result("m256", -256, 600);

    do_req(-512, 100, 500, 0);
    expect_result("m_neg512", 128, 450);

    do_req(0, 50, 20, 0);
    expect_result("m0", 16777215, 20);

    do_req(1, 2047, 0, 0);
    expect_result("sat_pos", -65536, 131071);

    do_req(-1, 2047, 0, 0);
    expect_result("sat_neg", 65536, -131072);

`ifdef PERP_ROUND_EN
    do_req(3, 10, 0, 0);
    expect_result("m3", -21845, 853);
`else
    do_req(3, 10, 0, 0);
    expect_result("m3", -21845, 854);
`endif

    // Second request 5 cycles after the first must be ignored.
    do_req(1, 100, 500, 0);
    repeat (4) @(negedge clk_in);
    m_in     = 25'sd256;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
    count_pulses(60, n, lm, lb);
    check("b2b_pulses", n, 1);
    check("b2b_m", lm, -65536);
    check("b2b_b", lb, 26100);

    // Request while tabulating is refused.
    @(negedge clk_in);
    tabulate_in = 1'b1;
    m_in        = 25'sd256;
    valid_in    = 1'b1;
    repeat (3) @(negedge clk_in);
    valid_in = 1'b0;
    count_pulses(40, n, lm, lb);
    check("tab_pulses", n, 0);
    check("tab_m", m_out, -65536);
    check("tab_b", b_out, 26100);
    tabulate_in = 1'b0;

    // Tabulate raised mid-computation does not abort.
    do_req(-512, 100, 500, 0);
    repeat (9) @(negedge clk_in);
    tabulate_in = 1'b1;
    count_pulses(40, n, lm, lb);
    check("tabmid_pulses", n, 1);
    check("tabmid_m", lm, 128);
    check("tabmid_b", lb, 450);
    check("tabmid_hold_m", m_out, 128);
    tabulate_in = 1'b0;

    // Reset during DIVIDE discards the result.
    do_req(256, 100, 500, 0);
    repeat (10) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("midrst_m", m_out, 0);
    check("midrst_b", b_out, 0);
    check("midrst_valid", valid_out, 0);
    count_pulses(40, n, lm, lb);
    check("midrst_pulses", n, 0);

    do_req(256, 100, 500, 0);
    expect_result("after_rst", -256, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perpendicularize.md
Name: perpendicularize

Overview:
- Takes a tracked line y = m·x + b and a centre-of-mass point (x_com, y_com), and produces the line perpendicular to it through that point: m_out = −1/m, b_out = y_com − m_out·x_com.
- Sits after the line-fit stage in the tracking pipeline and feeds the downstream geometry and overlay logic.
- Uses one sequential divider, so results are multi-cycle with fixed latency.

Parameters:
- FRAC_BITS, 8, fractional bits of the slope fixed-point format (Q16.8 signed).
- DIV_CYCLES, 24, iterations of the sequential divider (one quotient bit per cycle).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- m_in  input  25  signed slope, Q16.8 (1 sign, 16 integer, 8 fraction bits); 256 = 1.0.
- b_in  input  18  intercept of the input line, signed integer pixels; captured but not used in the output arithmetic.
- x_com  input  11  unsigned centre-of-mass x (0..2047).
- y_com  input  10  unsigned centre-of-mass y (0..1023).
- valid_in  input  1  start request; inputs are sampled on the accepting edge.
- tabulate_in  input  1  hold request; while high, new requests are refused and outputs freeze.
- m_out  output  25  signed Q16.8 perpendicular slope.
- b_out  output  18  signed integer intercept of the perpendicular line.
- valid_out  output  1  one-cycle pulse when m_out/b_out update.

Behaviour:
- Reset (synchronous, active-high, on clk_in): m_out=0, b_out=0, valid_out=0, FSM=IDLE. Reset mid-operation aborts the computation and discards any result.
- FSM states: IDLE, DIVIDE, COMBINE, DONE.
- IDLE: if valid_in=1 and tabulate_in=0, latch m_in, x_com, y_com and go to DIVIDE.
  - If tabulate_in=1, valid_in is ignored.
  - valid_in while not IDLE is ignored; there is no queueing.
- DIVIDE: compute |q| = 65536 / |m| (dividend = 1.0² in Q.8), unsigned restoring division, DIV_CYCLES cycles. Sign of m_out = opposite sign of m.
- m=0 (horizontal input): skip the division. m_out = +16777215 (0x0FFFFFF, max positive) and b_out = y_com; same total latency.
- COMBINE:
  - p = m_out·x_com (signed, at least 37 bits).
  - b = y_com − (p >>> 8), arithmetic shift (floor).
  - b_out saturates to [−131072, +131071].
- DONE: register m_out and b_out, pulse valid_out high for exactly one cycle, return to IDLE.
- Latency: valid_out is high in the cycle starting at the 26th rising edge after the accepting edge (1 capture + 24 divide + 1 combine); back-to-back throughput is one result per 27 cycles.
- m_out/b_out hold their last value between results.
- tabulate_in asserted mid-computation does not abort; the result still completes and is held.

Optional Feature:
- Macro PERP_ROUND_EN.
- Defined: divider rounds to nearest (adds |m|/2 to the dividend), and the product shift adds 128 before >>> 8.
- Undefined: quotient truncates toward zero and the shift floors.
- Latency is identical in both builds.

Decomposition:
- perpendicularize_pkg: width constants (M_W=25, B_W=18, X_W=11, Y_W=10), FRAC_BITS, ONE_SQ=65536, M_SAT=0x0FFFFFF, B_MAX=131071, B_MIN=−131072, and the FSM state enum.
- One sub-module: divider (unsigned sequential restoring divider with start/done handshake and DIV_CYCLES-cycle latency), instantiated once.

Test Plan:
- m_in=1, x_com=100, y_com=500, b_in=300, valid_in pulse -> 26 cycles later valid_out=1 for one cycle, m_out=−65536, b_out=26100.
- m_in=256, x_com=100, y_com=500 -> m_out=−256, b_out=600.
- m_in=−512, x_com=100, y_com=500 -> m_out=128, b_out=450.
- m_in=0, x_com=50, y_com=20 -> m_out=16777215, b_out=20; m_in=1, x_com=2047, y_com=0 -> b_out saturates to 131071.
- Second valid_in 5 cycles after the first -> ignored, exactly one valid_out pulse. valid_in with tabulate_in=1 -> no valid_out, outputs unchanged.
- rst_in asserted at cycle 10 of DIVIDE -> outputs 0, no valid_out; a fresh request afterwards completes normally.
